// File: rtl/burst_addr_gen_pkg.sv
// Shared types and elaboration helpers for the burst address generator.
// Used by burst_addr_gen (optional status outputs behind BURST_ADDR_GEN_STATUS_EN).
package burst_addr_gen_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // log2 of a power-of-two stride; evaluated at elaboration time only.
  function automatic int unsigned stride_log2(input int unsigned stride);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((stride >> i) == 32'd1) r = unsigned'(i);
    end
    return r;
  endfunction

endpackage

`ifndef BURST_ADDR_GEN_ASSERT_POW2
`define BURST_ADDR_GEN_ASSERT_POW2(val, maxv) \
  if ((val) == 0 || (((val) & ((val) - 1)) != 0) || (val) > (maxv)) begin : g_stride_check \
    $error("STRIDE must be a power of two within range"); \
  end
`endif

// File: rtl/burst_offset_cnt.sv
// Beat offset counter: steps by STRIDE, optionally wrapping to 0 at a ring window.
module burst_offset_cnt
  import burst_addr_gen_pkg::*;
#(
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned STRIDE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [LEN_W-1:0] win,
  output logic [LEN_W:0]   off
);

  localparam logic [LEN_W:0] STEP = (LEN_W + 1)'(STRIDE);

  logic [LEN_W:0] off_q, off_d, off_inc;

  always_comb begin
    off_inc = off_q + STEP;
    off_d   = off_q;
    if (clr) begin
      off_d = '0;
    end else if (inc) begin
      // win == 0 selects linear addressing
      if (win != '0 && off_inc >= {1'b0, win}) off_d = '0;
      else                                     off_d = off_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) off_q <= '0;
    else     off_q <= off_d;
  end

  assign off = off_q;

endmodule

// File: rtl/burst_addr_gen.sv
// Burst beat address generator with valid/ready issue and one-cycle done pulse.
// Optional beats_left/wrapped status outputs enabled by BURST_ADDR_GEN_STATUS_EN.
module burst_addr_gen
  import burst_addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned STRIDE = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] s_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic [LEN_W-1:0]  win,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic              busy,
  output logic              done
`ifdef BURST_ADDR_GEN_STATUS_EN
  ,
  output logic [LEN_W-1:0]  beats_left,
  output logic              wrapped
`endif
);

  localparam int unsigned    SUM_W = (ADDR_W > LEN_W + 1) ? ADDR_W : LEN_W + 1;
  localparam logic [LEN_W:0] STEP  = (LEN_W + 1)'(STRIDE);

  `BURST_ADDR_GEN_ASSERT_POW2(STRIDE, 2 ** (LEN_W - 1))

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q, win_q;
  logic [LEN_W:0]    cnt_q, off;
  logic              hs, last_beat, off_inc;

  assign hs        = (state_q == RUN) && addr_ready;
  assign last_beat = (cnt_q + STEP) >= {1'b0, len_q};
  // Offset freezes on the final beat so addr keeps showing the last issued beat in DONE.
  assign off_inc   = hs && !last_beat && !load;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = (len != '0) ? RUN : DONE;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     if (hs && last_beat) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        base_q <= s_addr;
        len_q  <= len;
        win_q  <= win;
        cnt_q  <= '0;
      end else if (hs) begin
        cnt_q <= cnt_q + STEP;
      end
    end
  end

  burst_offset_cnt #(
    .LEN_W  (LEN_W),
    .STRIDE (STRIDE)
  ) u_offset_cnt (
    .clk (clk),
    .rst (rst),
    .clr (load),
    .inc (off_inc),
    .win (win_q),
    .off (off)
  );

  assign addr       = ADDR_W'(SUM_W'(base_q) + SUM_W'(off));
  assign addr_valid = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);

`ifdef BURST_ADDR_GEN_STATUS_EN
  localparam int unsigned    STRIDE_LOG2 = stride_log2(STRIDE);
  localparam logic [LEN_W:0] STEP_M1     = (LEN_W + 1)'(STRIDE - 1);

  logic wrapped_q;

  assign beats_left = (state_q == RUN) ?
                      LEN_W'(({1'b0, len_q} - cnt_q + STEP_M1) >> STRIDE_LOG2) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrapped_q <= 1'b0;
    end else if (load) begin
      wrapped_q <= 1'b0;
    end else if (hs && win_q != '0 && (off + STEP) >= {1'b0, win_q}) begin
      wrapped_q <= 1'b1;
    end
  end

  assign wrapped = wrapped_q;
`endif

endmodule

// File: tb/tb_burst_addr_gen.sv
// Self-checking bench for burst_addr_gen: address-list model plus directed transfers.
module tb_burst_addr_gen;

  logic        clk = 1'b0;
  logic        rst, load, addr_valid, addr_ready, busy, done;
  logic [15:0] s_addr, len, win, addr;
`ifdef BURST_ADDR_GEN_STATUS_EN
  logic [15:0] beats_left;
  logic        wrapped;
`endif

  burst_addr_gen #(
    .ADDR_W (16),
    .LEN_W  (16),
    .STRIDE (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .s_addr     (s_addr),
    .len        (len),
    .win        (win),
    .addr       (addr),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .busy       (busy),
    .done       (done)
`ifdef BURST_ADDR_GEN_STATUS_EN
    ,
    .beats_left (beats_left),
    .wrapped    (wrapped)
`endif
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  logic [15:0] acc_log[$];
  int          done_total = 0;
  bit          prev_done = 1'b0;
  bit [7:0]    rdy_pat = 8'hFF;
  int          rdy_len = 1;
  int          rdy_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Consumer ready pattern, restarted at each load capture.
  always @(posedge clk) begin
    #1;
    addr_ready = rdy_pat[rdy_idx % rdy_len];
    rdy_idx++;
  end

  // Per-cycle compare against the expected beat list.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_eq_valid", busy, addr_valid);
      if (done) begin
        done_total++;
        chk("done_quiet", {addr_valid, busy}, 0);
        chk("done_single", prev_done, 0);
      end
      if (addr_valid) begin
        if (exp_q.size() == 0) begin
          chk("beats_pending", exp_q.size(), 1);
        end else begin
          chk("addr", addr, exp_q[0]);
`ifdef BURST_ADDR_GEN_STATUS_EN
          chk("beats_left", beats_left, exp_q.size());
`endif
          if (addr_ready) begin
            acc_log.push_back(addr);
            exp_q.delete(0);
          end
        end
      end else begin
`ifdef BURST_ADDR_GEN_STATUS_EN
        chk("beats_left_idle", beats_left, 0);
`endif
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic load_xfer(input logic [15:0] a, input logic [15:0] l, input logic [15:0] w);
    int nb, o;
    @(posedge clk);
    #1;
    load = 1'b1; s_addr = a; len = l; win = w;
    @(posedge clk);
    exp_q.delete();
    acc_log.delete();
    rdy_idx = 0;
    nb = (int'(l) + 7) / 8;
    for (int i = 0; i < nb; i++) begin
      o = (w != 16'd0) ? (i * 8) % int'(w) : i * 8;
      exp_q.push_back(16'(int'(a) + o));
    end
    #1;
    load = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic chk_log(input logic [15:0] lit[8], input int n);
    chk("beat_count", acc_log.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < acc_log.size()) chk("beat_value", acc_log[i], lit[i]);
    end
  endtask

  task automatic finish_xfer(input int exp_cycles, input int d0);
    int cyc;
    bit seen;
    wait_done(60, cyc, seen);
    chk("done_seen", seen, 1);
    chk("done_latency", cyc, exp_cycles);
    chk("beats_left_over", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    chk("done_count", done_total - d0, 1);
  endtask

  logic [15:0] lit[8];
  int          d0, cyc;
  bit          seen;

  initial begin
    rst = 1'b1; load = 1'b0; s_addr = '0; len = '0; win = '0; addr_ready = 1'b1;
    #12;
    chk("rst_addr", addr, 0);
    chk("rst_valid", addr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    // Linear, 4 full beats
    d0 = done_total;
    load_xfer(16'h0100, 16'd32, 16'd0);
    wait_done(60, cyc, seen);
    chk("t1_done_seen", seen, 1);
    chk("t1_latency", cyc, 5);
    chk("t1_addr_hold", addr, 16'h0118);
`ifdef BURST_ADDR_GEN_STATUS_EN
    chk("t1_wrapped", wrapped, 0);
`endif
    repeat (2) @(negedge clk);
    chk("t1_done_count", done_total - d0, 1);
    lit = '{16'h0100, 16'h0108, 16'h0110, 16'h0118, 16'h0, 16'h0, 16'h0, 16'h0};
    chk_log(lit, 4);

    // Partial final beat: ceil(20/8) = 3
    d0 = done_total;
    load_xfer(16'h0040, 16'd20, 16'd0);
    finish_xfer(4, d0);
    lit = '{16'h0040, 16'h0048, 16'h0050, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    chk_log(lit, 3);

    // Ring window of 16 bytes
    d0 = done_total;
    load_xfer(16'h2000, 16'd48, 16'd16);
    finish_xfer(7, d0);
    lit = '{16'h2000, 16'h2008, 16'h2000, 16'h2008, 16'h2000, 16'h2008, 16'h0, 16'h0};
    chk_log(lit, 6);
`ifdef BURST_ADDR_GEN_STATUS_EN
    chk("ring_wrapped", wrapped, 1);
`endif

    // Backpressure 1,0,0,1
    rdy_pat = 8'b0000_1001; rdy_len = 4;
    d0 = done_total;
    load_xfer(16'h0A00, 16'd32, 16'd0);
    finish_xfer(9, d0);
    lit = '{16'h0A00, 16'h0A08, 16'h0A10, 16'h0A18, 16'h0, 16'h0, 16'h0, 16'h0};
    chk_log(lit, 4);
    rdy_pat = 8'hFF; rdy_len = 1;

    // Empty transfer
    d0 = done_total;
    load_xfer(16'h1234, 16'd0, 16'd0);
    wait_done(60, cyc, seen);
    chk("len0_done_seen", seen, 1);
    chk("len0_latency", cyc, 1);
    chk("len0_addr_base", addr, 16'h1234);
    repeat (2) @(negedge clk);
    chk("len0_done_count", done_total - d0, 1);
    chk("len0_beats", acc_log.size(), 0);

    // Address-space wrap
    d0 = done_total;
    load_xfer(16'hFFF8, 16'd16, 16'd0);
    finish_xfer(3, d0);
    lit = '{16'hFFF8, 16'h0000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    chk_log(lit, 2);

    // Re-load mid-transfer: aborted transfer gives no done
    d0 = done_total;
    load_xfer(16'h0500, 16'd64, 16'd0);
    @(negedge clk);
    load_xfer(16'h0300, 16'd8, 16'd0);
    finish_xfer(2, d0);
    lit = '{16'h0300, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    chk_log(lit, 1);

    // Async reset mid-RUN
    d0 = done_total;
    load_xfer(16'h0700, 16'd64, 16'd0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("arst_addr", addr, 0);
    chk("arst_valid", addr_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
`ifdef BURST_ADDR_GEN_STATUS_EN
    chk("arst_beats_left", beats_left, 0);
    chk("arst_wrapped", wrapped, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("arst_no_done", done_total - d0, 0);
    chk("arst_idle", addr_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
